sprite_animator: RTL and testbench
==================================

# sprite_animator

Parametrised sprite pixel generator for the VGA display path. It turns the scan position into a sprite ROM address and returns a registered 16-bit colour plus a display flag, with a fixed 2-cycle latency. It sequences its own animation frames from a once-per-VGA-frame tick, and treats a colour-key pixel as transparent. It sits between the VGA scan counters (`vgac`) and the layer mixer, one instance per moving sprite (Kong, Mario, barrels).

## Interface
Parameters:
- `WIDTH`, 177: sprite width in pixels.
- `HEIGHT`, 117: sprite height in pixels.
- `FRAMES`, 4: number of animation frames stored back-to-back in the ROM (≥1).
- `PERIOD`, 8: `frame_tick` pulses per animation step (≥1).
- `ADDR_W`, `$clog2(FRAMES*WIDTH*HEIGHT)`: ROM address width.

Ports (clock and reset first):
- `clk` input 1: pixel clock. This is the one clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `x` input 10: scan column from vgac.
- `y` input 9: scan row from vgac.
- `posx` input 10: sprite left edge.
- `posy` input 9: sprite top edge.
- `isplay` input 1: sprite enabled. When 0, `is_display` is forced to 0.
- `frame_tick` input 1: one-cycle pulse per VGA frame.
- `anim_mode` input 2: animation mode, `HOLD`/`LOOP`/`PINGPONG`/`ONESHOT`.
- `anim_sel` input `$clog2(FRAMES)`: frame shown in `HOLD`.
- `anim_restart` input 1: pulse; returns the sequencer to frame 0, counting up.
- `mirror` input 1: horizontal flip. Only present with `SPRITE_MIRROR_EN`.
- `rom_addr` output `ADDR_W`: address to the synchronous sprite ROM.
- `rom_data` input 16: ROM data, valid 1 cycle after `rom_addr`.
- `color` output 16: pixel colour.
- `is_display` output 1: pixel is opaque and inside the sprite.
- `cur_frame` output `$clog2(FRAMES)`: the active frame.
- `anim_done` output 1: `ONESHOT` has finished.

## Operation
- Hit test: `hit = isplay & x>=posx & x<posx+WIDTH & y>=posy & y<posy+HEIGHT`. Compare at 11/10 bits so that `posx+WIDTH` does not wrap.
- Column: `col = x-posx`. With mirror active, `col = WIDTH-1-(x-posx)` instead.
- Row: `row = y-posy`.
- Address: `rom_addr = cur_frame*WIDTH*HEIGHT + row*WIDTH + col`. When `hit=0`, `rom_addr` holds 0.
- Transparency: if `rom_data == KEY_COLOR` (16'hffff), `is_display=0`. Otherwise `is_display = hit` delayed to match.
- `color = rom_data` when `is_display=1`, else `KEY_COLOR`.
- Tick counter, 0..PERIOD-1:
  - Increments on `frame_tick`.
  - At PERIOD-1 it wraps to 0 and issues a step.
  - It does not count while the mode is `HOLD` or `anim_done=1`.
- Frame sequencer states: `HOLD`, `RUN_UP`, `RUN_DOWN`, `DONE`.
  - `HOLD`: `cur_frame = anim_sel`. Values of `anim_sel` ≥ FRAMES clamp to FRAMES-1.
  - `LOOP`: on each step, frame+1, wrapping FRAMES-1 → 0.
  - `PINGPONG`: counts up to FRAMES-1, then down to 0, then up again. Each end frame is shown for one period only.
  - `ONESHOT`: counts up. On reaching FRAMES-1 it enters `DONE`, asserts `anim_done`, and stays there.
- `FRAMES=1`: `cur_frame` stays 0. `ONESHOT` asserts `anim_done` on its first step.
- Restart:
  - `anim_restart` clears the frame, the tick counter, `anim_done` and the direction to up on the next edge.
  - If a step or tick arrives in the same cycle, restart wins.
- Mode change takes effect on the next edge. Frame and direction are kept, and the tick counter clears.
- `cur_frame` changes only on clock edges. It may change mid-scan; no vsync alignment is done beyond the tick input.

## Timing
- Stage 0 (edge k): register `hit`, `rom_addr` and the sequencer state.
- Stage 1: the ROM returns `rom_data`; `hit` is delayed one cycle.
- Stage 2 (edge k+2): register `color` and `is_display`.
- Total latency from `x`/`y` to `color`/`is_display` is 2 cycles. The mixer must delay its other layers to match.
- A step on a `frame_tick` at edge t updates `cur_frame` at edge t. It affects `rom_addr` from t+1.
- Reset values (asynchronous on `rst_n=0`):
  - `color = 16'hffff`, `is_display = 0`, `rom_addr = 0`.
  - `cur_frame = 0`, `anim_done = 0`, tick counter 0, direction up.
  - Pipeline valid bits 0.
- Reset deassert mid-scan: output is transparent until the pipeline has refilled, i.e. the first 2 cycles.

## Configuration
- `SPRITE_MIRROR_EN` defined: the `mirror` port exists and the flipped column mapping applies.
- Undefined: the port is absent and `col = x-posx` always. Behaviour is otherwise identical.

## Structure
- Package `sprite_pkg`:
  - `KEY_COLOR = 16'hffff`.
  - `anim_mode_t` enum: `HOLD`=0, `LOOP`=1, `PINGPONG`=2, `ONESHOT`=3.
  - Sequencer state enum.
- Sub-module `sprite_frame_seq` holds the tick counter, direction and `cur_frame`/`anim_done` FSM. The top level keeps the hit test, address arithmetic and output pipeline.

## Test plan
- Reset check: assert `rst_n=0` mid-pixel → `color=16'hffff`, `is_display=0`, `cur_frame=0` immediately. After release, the first valid output appears 2 cycles after the first hit.
- Address and latency: WIDTH=4, HEIGHT=3, FRAMES=2, `posx=10`, `posy=20`, `x=12`, `y=21`, `HOLD`, `anim_sel=1` → `rom_addr=12+4+2=18`. `color` equals the ROM word 2 cycles later.
- Edges and transparency:
  - `x=9` or `x=14` → `is_display=0`.
  - ROM word 16'hffff at a hit → `is_display=0`.
  - `isplay=0` → `is_display=0`.
- `LOOP`/`PINGPONG` sequence: PERIOD=2, FRAMES=3.
  - `LOOP` over 12 ticks → frames 0,0,1,1,2,2,0,…
  - `PINGPONG` → 0,1,2,1,0,1 per step.
- `ONESHOT` and restart:
  - FRAMES=3: `anim_done=1` at frame 2 and the frame is held through later ticks.
  - `anim_restart` together with `frame_tick` → frame 0, `anim_done=0`, tick counter 0.
- Mirror (`SPRITE_MIRROR_EN`): WIDTH=4, `mirror=1`, `x=posx` → col 3. With the macro undefined → col 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite animator.
package sprite_pkg;

  // Colour value that marks a transparent pixel in the sprite ROM
  localparam logic [15:0] KEY_COLOR = 16'hffff;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    LOOP     = 2'd1,
    PINGPONG = 2'd2,
    ONESHOT  = 2'd3
  } anim_mode_t;

  typedef enum logic [1:0] {
    SEQ_HOLD     = 2'd0,
    SEQ_RUN_UP   = 2'd1,
    SEQ_RUN_DOWN = 2'd2,
    SEQ_DONE     = 2'd3
  } seq_state_t;

  // Index width that stays at least one bit for single-entry ranges
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_frame_seq.sv
// Animation frame sequencer: tick prescaler, direction and cur_frame FSM.
// The FSM state is exported so the current phase (hold/up/down/done) is visible.
module sprite_frame_seq
  import sprite_pkg::*;
#(
  parameter int FRAMES = 4,
  parameter int PERIOD = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic [1:0]                    anim_mode,
  input  logic [safe_clog2(FRAMES)-1:0] anim_sel,
  input  logic                          anim_restart,
  output logic [safe_clog2(FRAMES)-1:0] cur_frame,
  output seq_state_t                    state
);

  localparam int FW = safe_clog2(FRAMES);
  localparam int TW = safe_clog2(PERIOD);
  localparam logic [FW-1:0] LAST = FW'(FRAMES - 1);

  anim_mode_t     mode;
  anim_mode_t     mode_q;
  seq_state_t     state_q, state_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic           dir_down_q, dir_down_d;
  logic           done_d;
  logic           step;
  logic [FW-1:0]  sel_clamped;

  assign mode        = anim_mode_t'(anim_mode);
  assign sel_clamped = (32'(anim_sel) > 32'(FRAMES - 1)) ? LAST : anim_sel;

  // State register: sequencer phase, frame, prescaler, direction, last mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_HOLD;
      frame_q    <= '0;
      tick_q     <= '0;
      dir_down_q <= 1'b0;
      mode_q     <= HOLD;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tick_q     <= tick_d;
      dir_down_q <= dir_down_d;
      mode_q     <= mode;
    end
  end

  // Next state: restart beats everything, a mode change clears the prescaler
  always_comb begin
    frame_d    = frame_q;
    tick_d     = tick_q;
    dir_down_d = dir_down_q;
    done_d     = (state_q == SEQ_DONE);
    step       = 1'b0;
    state_d    = state_q;
    if (anim_restart) begin
      frame_d    = '0;
      tick_d     = '0;
      dir_down_d = 1'b0;
      done_d     = 1'b0;
    end else if (state_q == SEQ_DONE) begin
      // finished one-shot stays frozen until restarted
    end else if (mode != mode_q) begin
      tick_d = '0;
      if (mode == HOLD) frame_d = sel_clamped;
    end else if (mode == HOLD) begin
      frame_d = sel_clamped;
    end else if (frame_tick) begin
      if (tick_q == TW'(PERIOD - 1)) begin
        tick_d = '0;
        step   = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
    if (step) begin
      case (mode)
        LOOP: frame_d = (frame_q == LAST) ? '0 : frame_q + FW'(1);
        PINGPONG: begin
          if (FRAMES > 1) begin
            if (dir_down_q) begin
              if (frame_q == '0) begin
                frame_d    = FW'(1);
                dir_down_d = 1'b0;
              end else begin
                frame_d = frame_q - FW'(1);
              end
            end else begin
              if (frame_q == LAST) begin
                frame_d    = LAST - FW'(1);
                dir_down_d = 1'b1;
              end else begin
                frame_d = frame_q + FW'(1);
              end
            end
          end
        end
        ONESHOT: begin
          if (frame_q != LAST) frame_d = frame_q + FW'(1);
          done_d = (frame_d == LAST);
        end
        default: ;
      endcase
    end
    if (done_d)              state_d = SEQ_DONE;
    else if (mode == HOLD)   state_d = SEQ_HOLD;
    else if (dir_down_d)     state_d = SEQ_RUN_DOWN;
    else                     state_d = SEQ_RUN_UP;
  end

  // Outputs: registered frame and the visible FSM phase
  always_comb begin
    cur_frame = frame_q;
    state     = state_q;
  end

endmodule

// File: rtl/sprite_animator.sv
// Sprite pixel generator: hit test, ROM addressing and a 2-cycle colour pipeline.
// Optional horizontal flip is built when SPRITE_MIRROR_EN is defined.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int WIDTH  = 177,
  parameter int HEIGHT = 117,
  parameter int FRAMES = 4,
  parameter int PERIOD = 8,
  parameter int ADDR_W = $clog2(FRAMES * WIDTH * HEIGHT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    x,
  input  logic [8:0]                    y,
  input  logic [9:0]                    posx,
  input  logic [8:0]                    posy,
  input  logic                          isplay,
  input  logic                          frame_tick,
  input  logic [1:0]                    anim_mode,
  input  logic [safe_clog2(FRAMES)-1:0] anim_sel,
  input  logic                          anim_restart,
`ifdef SPRITE_MIRROR_EN
  input  logic                          mirror,
`endif
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [15:0]                   rom_data,
  output logic [15:0]                   color,
  output logic                          is_display,
  output logic [safe_clog2(FRAMES)-1:0] cur_frame,
  output logic                          anim_done
);

  logic [10:0]       x_end;
  logic [9:0]        y_end;
  logic              hit;
  logic [9:0]        col_raw, col;
  logic [8:0]        row;
  logic [ADDR_W-1:0] addr;
  logic              hit_q, hit_d;
  logic              opaque;
  seq_state_t        seq_state;

  sprite_frame_seq #(
    .FRAMES (FRAMES),
    .PERIOD (PERIOD)
  ) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .anim_mode    (anim_mode),
    .anim_sel     (anim_sel),
    .anim_restart (anim_restart),
    .cur_frame    (cur_frame),
    .state        (seq_state)
  );

  assign anim_done = (seq_state == SEQ_DONE);

  // Hit test with one extra bit so the right/bottom edge cannot wrap
  always_comb begin
    x_end   = {1'b0, posx} + 11'(WIDTH);
    y_end   = {1'b0, posy} + 10'(HEIGHT);
    hit     = isplay && (x >= posx) && ({1'b0, x} < x_end)
                     && (y >= posy) && ({1'b0, y} < y_end);
    col_raw = x - posx;
    row     = y - posy;
`ifdef SPRITE_MIRROR_EN
    col     = mirror ? (10'(WIDTH - 1) - col_raw) : col_raw;
`else
    col     = col_raw;
`endif
    addr    = ADDR_W'(32'(cur_frame) * 32'(WIDTH * HEIGHT)
                    + 32'(row) * 32'(WIDTH) + 32'(col));
  end

  // Stage 0/1: ROM address and hit, then hit delayed to line up with rom_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      hit_q    <= 1'b0;
      hit_d    <= 1'b0;
    end else begin
      rom_addr <= hit ? addr : '0;
      hit_q    <= hit;
      hit_d    <= hit_q;
    end
  end

  assign opaque = hit_d && (rom_data != KEY_COLOR);

  // Stage 2: registered colour, key colour whenever the pixel is not shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color      <= KEY_COLOR;
      is_display <= 1'b0;
    end else begin
      color      <= opaque ? rom_data : KEY_COLOR;
      is_display <= opaque;
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed cases from the block description plus
// randomized scan/animation traffic checked against a behavioural model.
module tb_sprite_animator;
  import sprite_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int F  = 3;
  localparam int P  = 2;
  localparam int N  = F * W * H;
  localparam int AW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0]    x, posx;
  logic [8:0]    y, posy;
  logic          isplay, frame_tick, anim_restart, mirror;
  logic [1:0]    anim_mode, anim_sel;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data, color;
  logic          is_display, anim_done;
  logic [1:0]    cur_frame;

  sprite_animator #(
    .WIDTH (W), .HEIGHT (H), .FRAMES (F), .PERIOD (P)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .y            (y),
    .posx         (posx),
    .posy         (posy),
    .isplay       (isplay),
    .frame_tick   (frame_tick),
    .anim_mode    (anim_mode),
    .anim_sel     (anim_sel),
    .anim_restart (anim_restart),
`ifdef SPRITE_MIRROR_EN
    .mirror       (mirror),
`endif
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .color        (color),
    .is_display   (is_display),
    .cur_frame    (cur_frame),
    .anim_done    (anim_done)
  );

  // Synchronous sprite ROM
  logic [15:0] rom [0:N-1];
  always @(posedge clk) rom_data <= (int'(rom_addr) < N) ? rom[int'(rom_addr) % N] : 16'h0000;

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [16:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_frame, m_tick, m_dir, m_done, m_prev;

  task automatic model_reset();
    m_frame = 0; m_tick = 0; m_dir = 1; m_done = 0; m_prev = 0;
    exp_q.delete();
    exp_q.push_back({1'b0, KEY_COLOR});
    exp_q.push_back({1'b0, KEY_COLOR});
  endtask

  task automatic seq_model();
    int mode, sel;
    mode = int'(anim_mode);
    sel  = (int'(anim_sel) >= F) ? F - 1 : int'(anim_sel);
    if (anim_restart) begin
      m_frame = 0; m_tick = 0; m_done = 0; m_dir = 1;
    end else if (m_done != 0) begin
    end else if (mode != m_prev) begin
      m_tick = 0;
      if (mode == 0) m_frame = sel;
    end else if (mode == 0) begin
      m_frame = sel;
    end else if (frame_tick) begin
      m_tick++;
      if (m_tick == P) begin
        m_tick = 0;
        case (mode)
          1: m_frame = (m_frame + 1) % F;
          2: begin
            if (m_frame + m_dir < 0 || m_frame + m_dir > F - 1) m_dir = -m_dir;
            m_frame = m_frame + m_dir;
          end
          default: begin
            if (m_frame < F - 1) m_frame++;
            if (m_frame == F - 1) m_done = 1;
          end
        endcase
      end
    end
    m_prev = mode;
  endtask

  // One clock: predict, advance, compare address, sequencer and pixel output
  task automatic step_cycle();
    int col, row, addr, ea;
    bit hit;
    logic [15:0] word;
    logic [16:0] e;
    hit = isplay && int'(x) >= int'(posx) && int'(x) < int'(posx) + W
                 && int'(y) >= int'(posy) && int'(y) < int'(posy) + H;
    col = int'(x) - int'(posx);
`ifdef SPRITE_MIRROR_EN
    if (mirror) col = W - 1 - col;
`endif
    row  = int'(y) - int'(posy);
    addr = m_frame * W * H + row * W + col;
    ea   = hit ? addr : 0;
    word = hit ? rom[addr] : KEY_COLOR;
    e    = (hit && word != KEY_COLOR) ? {1'b1, word} : {1'b0, KEY_COLOR};
    exp_q.push_back(e);
    seq_model();
    @(posedge clk);
    #1;
    check_eq("rom_addr", 32'(rom_addr), ea);
    check_eq("cur_frame", 32'(cur_frame), m_frame);
    check_eq("anim_done", 32'(anim_done), m_done);
    e = exp_q.pop_front();
    check_eq("pixel", {15'd0, is_display, color}, {15'd0, e});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pos(input int px, input int py, input int sx, input int sy);
    posx = 10'(px); posy = 9'(py); x = 10'(sx); y = 9'(sy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic restart_mode(input logic [1:0] m);
    anim_mode = m; anim_restart = 1'b1;
    step_cycle();
    anim_restart = 1'b0;
  endtask

  task automatic one_tick();
    frame_tick = 1'b1; step_cycle();
    frame_tick = 1'b0; step_cycle();
  endtask

  int loop_exp[12] = '{0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};
  int pp_exp[6]    = '{1, 2, 1, 0, 1, 2};

  initial begin
    for (int i = 0; i < N; i++) rom[i] = ($urandom_range(0, 4) == 0) ? 16'hffff : 16'($urandom);
    rom[6]  = 16'h0606;
    rom[17] = 16'hffff;
    rom[18] = 16'h1234;
    rom[19] = 16'h0abc;

    rst_n = 1'b0; isplay = 1'b1; frame_tick = 1'b0; anim_restart = 1'b0;
    anim_mode = 2'd0; anim_sel = 2'd1; mirror = 1'b0;
    set_pos(10, 20, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_color", 32'(color), 32'hffff);
    check_eq("rst_disp", 32'(is_display), 0);
    check_eq("rst_addr", 32'(rom_addr), 0);
    check_eq("rst_frame", 32'(cur_frame), 0);
    check_eq("rst_done", 32'(anim_done), 0);
    rst_n = 1'b1;
    model_reset();

    // Address and latency: HOLD frame 1, x=12 y=21 -> 12+4+2
    run(3);
    x = 10'd12; y = 9'd21;
    step_cycle();
    check_eq("addr_18", 32'(rom_addr), 18);
    step_cycle();
    check_eq("lat_early", 32'(is_display), 0);
    step_cycle();
    check_eq("lat_color", 32'(color), 32'h1234);
    check_eq("lat_disp", 32'(is_display), 1);

    // Edges, transparency, disable
    x = 10'd13; run(3); check_eq("last_col", 32'(color), 32'h0abc);
    x = 10'd14; run(3); check_eq("right_out", 32'(is_display), 0);
    x = 10'd9;  run(3); check_eq("left_out", 32'(is_display), 0);
    x = 10'd11; run(3); check_eq("key_pix", 32'(is_display), 0);
    x = 10'd12; isplay = 1'b0; run(3); check_eq("isplay_off", 32'(is_display), 0);
    isplay = 1'b1; run(3);

    // Asynchronous reset in the middle of a displayed pixel
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_color", 32'(color), 32'hffff);
    check_eq("mid_rst_disp", 32'(is_display), 0);
    check_eq("mid_rst_frame", 32'(cur_frame), 0);
    #2 rst_n = 1'b1;
    model_reset();
    step_cycle(); step_cycle();
    check_eq("refill_gap", 32'(is_display), 0);
    step_cycle();
    check_eq("refill_color", 32'(color), 32'h0606);

    // HOLD clamps out-of-range selections
    anim_sel = 2'd3; run(2);
    check_eq("clamp", 32'(cur_frame), 2);

    // LOOP sequence, one check per tick
    restart_mode(2'd1);
    for (int i = 0; i < 12; i++) begin
      one_tick();
      check_eq("loop_seq", 32'(cur_frame), loop_exp[i]);
    end

    // PINGPONG sequence, one check per step
    restart_mode(2'd2);
    for (int i = 0; i < 6; i++) begin
      one_tick(); one_tick();
      check_eq("pp_seq", 32'(cur_frame), pp_exp[i]);
    end

    // ONESHOT finishes on the last frame and stays there
    restart_mode(2'd3);
    for (int i = 0; i < 4; i++) one_tick();
    check_eq("os_frame", 32'(cur_frame), 2);
    check_eq("os_done", 32'(anim_done), 1);
    for (int i = 0; i < 4; i++) one_tick();
    check_eq("os_held", 32'(cur_frame), 2);
    anim_restart = 1'b1; frame_tick = 1'b1; step_cycle();
    anim_restart = 1'b0; frame_tick = 1'b0;
    check_eq("rs_frame", 32'(cur_frame), 0);
    check_eq("rs_done", 32'(anim_done), 0);
    one_tick(); check_eq("rs_tick0", 32'(cur_frame), 0);
    one_tick(); check_eq("rs_step", 32'(cur_frame), 1);

    // Column mapping at the left edge, frame 0 row 1
    anim_mode = 2'd0; anim_sel = 2'd0;
    set_pos(10, 20, 10, 21);
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b1;
    run(3); check_eq("mirror_col", 32'(rom_addr), 7);
    mirror = 1'b0;
`else
    run(3); check_eq("plain_col", 32'(rom_addr), 4);
`endif

    // Randomized scan and animation traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: begin posx = 10'd10; posy = 9'd20; end
          1: begin posx = 10'd1021; posy = 9'd509; end
          default: begin posx = 10'($urandom); posy = 9'($urandom); end
        endcase
      end
      if ($urandom_range(0, 39) == 0) anim_mode = 2'($urandom_range(0, 3));
      x = 10'(int'(posx) + int'($urandom_range(0, W + 3)) - 2);
      y = 9'(int'(posy) + int'($urandom_range(0, H + 3)) - 2);
      isplay       = ($urandom_range(0, 9) != 0);
      frame_tick   = ($urandom_range(0, 2) == 0);
      anim_restart = ($urandom_range(0, 49) == 0);
      anim_sel     = 2'($urandom_range(0, 3));
`ifdef SPRITE_MIRROR_EN
      mirror       = 1'($urandom_range(0, 1));
`endif
      step_cycle();
    end
    frame_tick = 1'b0; anim_restart = 1'b0;
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
